// File: rtl/l2_tag_directory.sv
// 8-way L2 tag/MESI directory with 7-bit tree pseudo-LRU; presents the looked-up way
// to the MESI next-state block and writes back its answer. MESI encoding: I=00 S=01 E=10 M=11.
module l2_tag_directory #(
  parameter int ADDR_W      = 32,
  parameter int OFFSET_BITS = 6,
  parameter int INDEX_BITS  = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_cmd,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              mesi_valid,
  output logic [3:0]        mesi_cmd,
  output logic [1:0]        mesi_bits,
  output logic              mesi_miss,
  input  logic [1:0]        mesi_next,
  output logic              resp_done,
  output logic              resp_hit,
  output logic [2:0]        resp_way,
  output logic              victim_valid,
  output logic              victim_dirty,
  output logic [ADDR_W-1:0] victim_addr,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_hits,
  output logic [31:0]       stat_misses
);
  localparam int TAG_W = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int SETS  = 1 << INDEX_BITS;
  localparam logic [1:0] MESI_I  = 2'b00;
  localparam logic [1:0] MESI_M  = 2'b11;
  localparam logic [3:0] CMD_CLR = 4'd8;

  typedef enum logic [1:0] {CLEAR, IDLE, LOOKUP, RESP} state_t;

  state_t                st;
  logic [INDEX_BITS-1:0] clr_idx;

  logic [15:0]        st_arr   [SETS];
  logic [8*TAG_W-1:0] tag_arr  [SETS];
  logic [6:0]         plru_arr [SETS];

  logic [INDEX_BITS-1:0] idx_in;
  logic [TAG_W-1:0]      tag_in;
  logic                  unused_offset;
  logic [15:0]           set_st;
  logic [8*TAG_W-1:0]    set_tag;
  logic                  lk_hit, lk_free;
  logic [2:0]            lk_hit_way, lk_free_way, lk_way;
  logic [1:0]            lk_state;
  logic [TAG_W-1:0]      lk_tag;

  logic [3:0]            cmd_p1;
  logic [INDEX_BITS-1:0] idx_p1;
  logic [TAG_W-1:0]      tag_p1, vtag_p1;
  logic                  hit_p1;
  logic [2:0]            way_p1;
  logic [1:0]            vst_p1;
  logic                  accept, is_alloc, is_snoop, is_lookup;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  // Bit set = victim lies in the upper half of that node's subtree.
  function automatic logic [2:0] plru_victim(input logic [6:0] b);
    logic [2:0] v;
    v[2] = b[0];
    v[1] = v[2] ? b[2] : b[1];
    v[0] = b[3'd3 + {1'b0, v[2], v[1]}];
    return v;
  endfunction

  function automatic logic [6:0] plru_touch(input logic [6:0] b, input logic [2:0] w);
    logic [6:0] n;
    n = b;
    n[0] = ~w[2];
    if (w[2]) n[2] = ~w[1];
    else      n[1] = ~w[1];
    n[3'd3 + {1'b0, w[2:1]}] = ~w[0];
    return n;
  endfunction

  assign idx_in        = req_addr[OFFSET_BITS +: INDEX_BITS];
  assign tag_in        = req_addr[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^req_addr[OFFSET_BITS-1:0];
  assign accept        = (st == IDLE) && req_valid && req_ready;
  assign is_alloc      = (cmd_p1 <= 4'd2);
  assign is_snoop      = (cmd_p1 >= 4'd3) && (cmd_p1 <= 4'd6);
  assign is_lookup     = (cmd_p1 <= 4'd6);

  // Stage 0: set read and way selection on the incoming address
  always_comb begin
    set_st      = st_arr[idx_in];
    set_tag     = tag_arr[idx_in];
    lk_hit      = 1'b0;
    lk_hit_way  = 3'd0;
    lk_free     = 1'b0;
    lk_free_way = 3'd0;
    for (int w = 7; w >= 0; w--) begin
      if (set_st[2*w +: 2] == MESI_I) begin
        lk_free     = 1'b1;
        lk_free_way = 3'(w);
      end else if (set_tag[TAG_W*w +: TAG_W] == tag_in) begin
        lk_hit     = 1'b1;
        lk_hit_way = 3'(w);
      end
    end
    lk_way   = lk_hit ? lk_hit_way : (lk_free ? lk_free_way : plru_victim(plru_arr[idx_in]));
    lk_state = set_st[{lk_way, 1'b0} +: 2];
    lk_tag   = set_tag[int'(lk_way)*TAG_W +: TAG_W];
  end

  // Stage 1: request and selected-way snapshot held through LOOKUP
  always_ff @(posedge clk) begin
    if (accept) begin
      cmd_p1  <= req_cmd;
      idx_p1  <= idx_in;
      tag_p1  <= tag_in;
      hit_p1  <= lk_hit && (req_cmd <= 4'd6);
      way_p1  <= ((lk_hit && req_cmd <= 4'd6) || req_cmd <= 4'd2) ? lk_way : 3'd0;
      vst_p1  <= lk_state;
      vtag_p1 <= lk_tag;
    end
  end

  // An async reset forces st to CLEAR, so an in-flight LOOKUP write never lands.
  always_ff @(posedge clk) begin
    if (st == CLEAR) begin
      st_arr[clr_idx]   <= {8{MESI_I}};
      plru_arr[clr_idx] <= 7'd0;
    end else if (st == LOOKUP) begin
      if (is_alloc) begin
        st_arr[idx_p1][{way_p1, 1'b0} +: 2] <= mesi_next;
        if (!hit_p1) tag_arr[idx_p1][int'(way_p1)*TAG_W +: TAG_W] <= tag_p1;
        plru_arr[idx_p1] <= plru_touch(plru_arr[idx_p1], way_p1);
      end else if (is_snoop && hit_p1) begin
        st_arr[idx_p1][{way_p1, 1'b0} +: 2] <= mesi_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= CLEAR;
      clr_idx      <= '0;
      req_ready    <= 1'b0;
      mesi_valid   <= 1'b0;
      mesi_cmd     <= 4'd0;
      mesi_bits    <= 2'd0;
      mesi_miss    <= 1'b0;
      resp_done    <= 1'b0;
      resp_hit     <= 1'b0;
      resp_way     <= 3'd0;
      victim_valid <= 1'b0;
      victim_dirty <= 1'b0;
      victim_addr  <= '0;
      stat_reads   <= 32'd0;
      stat_writes  <= 32'd0;
      stat_hits    <= 32'd0;
      stat_misses  <= 32'd0;
    end else begin
      case (st)
        CLEAR: begin
          clr_idx <= clr_idx + 1'b1;
          if (clr_idx == {INDEX_BITS{1'b1}}) begin
            st        <= IDLE;
            req_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            if (req_cmd == CMD_CLR) begin
              st      <= CLEAR;
              clr_idx <= '0;
            end else begin
              // No-op commands also pass through LOOKUP (without mesi_valid) for uniform latency.
              st <= LOOKUP;
              if (req_cmd <= 4'd6) begin
                mesi_valid <= 1'b1;
                mesi_cmd   <= req_cmd;
                mesi_bits  <= lk_hit ? lk_state : MESI_I;
                mesi_miss  <= !lk_hit;
              end
            end
          end
        end
        LOOKUP: begin
          st         <= RESP;
          mesi_valid <= 1'b0;
          resp_done  <= 1'b1;
          resp_hit   <= hit_p1 && is_lookup;
          resp_way   <= way_p1;
          if (is_alloc && !hit_p1 && vst_p1 != MESI_I) begin
            victim_valid <= 1'b1;
            victim_dirty <= (vst_p1 == MESI_M);
            victim_addr  <= {vtag_p1, idx_p1, {OFFSET_BITS{1'b0}}};
          end
          if (is_alloc) begin
            if (cmd_p1 == 4'd1) stat_writes <= sat_inc(stat_writes);
            else                stat_reads  <= sat_inc(stat_reads);
            if (hit_p1) stat_hits   <= sat_inc(stat_hits);
            else        stat_misses <= sat_inc(stat_misses);
          end
        end
        RESP: begin
          st           <= IDLE;
          req_ready    <= 1'b1;
          resp_done    <= 1'b0;
          resp_hit     <= 1'b0;
          resp_way     <= 3'd0;
          victim_valid <= 1'b0;
          victim_dirty <= 1'b0;
          victim_addr  <= '0;
        end
        default: st <= CLEAR;
      endcase
    end
  end
endmodule
